// File: rtl/mem_stage_lsu_pkg.sv
// Shared definitions for the M-stage load/store unit.
// Holds the opcode constants, the ExcCode values (AdEL=4, AdES=5) and the data-memory range.
// It also holds the FSM state encoding (IDLE=0, REQ=1, DONE=2), the access decode and the bus command payload.
package mem_stage_lsu_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned BE_W        = 4;
    localparam int unsigned EXC_W       = 5;
    localparam int unsigned STATE_W     = 2;
    localparam int unsigned TO_CNT_W    = 5;
    localparam int unsigned TIMEOUT_CYC = 16;

    localparam logic [XLEN-1:0] DM_TOP_DEF = 32'h0000_2FFF;

    // MIPS primary opcodes (Instr[31:26]) handled by this stage
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    localparam logic [EXC_W-1:0] EXC_NONE = 5'd0;
    localparam logic [EXC_W-1:0] EXC_ADEL = 5'd4;
    localparam logic [EXC_W-1:0] EXC_ADES = 5'd5;

    localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
    localparam logic [STATE_W-1:0] ST_REQ  = 2'd1;
    localparam logic [STATE_W-1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } mem_size_e;

    typedef struct packed {
        logic      valid;
        logic      store;
        mem_size_e size;
        logic      uns;
    } mem_dec_t;

    typedef struct packed {
        logic            we;
        logic [XLEN-1:0] addr;
        logic [BE_W-1:0] be;
        logic [XLEN-1:0] wdata;
    } bus_cmd_t;

    // Opcode -> access kind; non-memory opcodes decode with valid=0
    function automatic mem_dec_t lsu_decode(input logic [5:0] op);
        mem_dec_t d;
        d = '0;
        d.size = SZ_W;
        case (op)
            OP_LB:  begin d.valid = 1'b1; d.size = SZ_B; end
            OP_LBU: begin d.valid = 1'b1; d.size = SZ_B; d.uns = 1'b1; end
            OP_LH:  begin d.valid = 1'b1; d.size = SZ_H; end
            OP_LHU: begin d.valid = 1'b1; d.size = SZ_H; d.uns = 1'b1; end
            OP_LW:  begin d.valid = 1'b1; d.size = SZ_W; end
            OP_SB:  begin d.valid = 1'b1; d.store = 1'b1; d.size = SZ_B; end
            OP_SH:  begin d.valid = 1'b1; d.store = 1'b1; d.size = SZ_H; end
            OP_SW:  begin d.valid = 1'b1; d.store = 1'b1; d.size = SZ_W; end
            default: d.valid = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Single-outstanding req/ack data bus between the LSU (master) and data memory (slave).
//   req   : request, held until ack is sampled high
//   we    : 1 = write
//   addr  : word-aligned byte address
//   be    : byte enables
//   wdata : lane-aligned write data
//   ack   : completion; rdata valid in the same cycle
//   rdata : read data
interface mem_stage_lsu_if;
    import mem_stage_lsu_pkg::*;

    logic            req;
    logic            we;
    logic [XLEN-1:0] addr;
    logic [BE_W-1:0] be;
    logic [XLEN-1:0] wdata;
    logic            ack;
    logic [XLEN-1:0] rdata;

    modport master (output req, we, addr, be, wdata, input ack, rdata);
    modport slave  (input req, we, addr, be, wdata, output ack, rdata);

endinterface

// File: rtl/mem_stage_lsu_ext.sv
// Load-data formatter: selects the byte/half lane from a bus word and sign/zero extends it.
//   rdata  : raw bus word
//   size   : access size (byte/half/word)
//   uns    : 1 = zero extend, 0 = sign extend
//   off    : byte offset of the access (addr[1:0])
//   data_c : extended result (combinational)
module mem_stage_lsu_ext
    import mem_stage_lsu_pkg::*;
(
    input  logic [XLEN-1:0] rdata,
    input  mem_size_e       size,
    input  logic            uns,
    input  logic [1:0]      off,
    output logic [XLEN-1:0] data_c
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Little-endian lane pick followed by extension
    always_comb begin
        byte_sel = rdata[7:0];
        case (off)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = off[1] ? rdata[31:16] : rdata[15:0];

        data_c = rdata;
        case (size)
            SZ_B:    data_c = uns ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            SZ_H:    data_c = uns ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: data_c = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// M-stage load/store unit.
// Decodes lw/lh/lhu/lb/lbu/sw/sh/sb and checks alignment and range (AdEL/AdES).
// Runs one req/ack bus access per instruction and stalls the pipe until the access completes.
// Optional macro LSU_TIMEOUT_EN: REQ gives up after TIMEOUT_CYC cycles without ack and reports AdEL/AdES.
//   clk, reset   : clock; asynchronous active-high reset
//   Instr_M      : M-stage instruction
//   RT_M         : store data
//   ALU_M        : effective address
//   ExcCode_Min  : exception code from earlier stages (0 = none)
//   flush_M      : kill the current M instruction
//   bus          : data bus master port
//   MemRd_M      : extended load result, valid in DONE
//   stall_M      : freeze F..M (combinational)
//   ExcCode_Mout : merged exception code (combinational)
module mem_stage_lsu
    import mem_stage_lsu_pkg::*;
#(
    parameter logic [XLEN-1:0] DM_TOP = DM_TOP_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [XLEN-1:0]  Instr_M,
    input  logic [XLEN-1:0]  RT_M,
    input  logic [XLEN-1:0]  ALU_M,
    input  logic [EXC_W-1:0] ExcCode_Min,
    input  logic             flush_M,
    mem_stage_lsu_if.master  bus,
    output logic [XLEN-1:0]  MemRd_M,
    output logic             stall_M,
    output logic [EXC_W-1:0] ExcCode_Mout
);

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;

    mem_dec_t        dec_c;
    logic            misalign_c;
    logic            exc_addr_c;
    logic            exc_up_c;
    logic            go_c;
    bus_cmd_t        cmd_c;
    bus_cmd_t        cmd_q;
    logic            req_q;
    logic            kill_q;
    mem_size_e       ld_size_q;
    logic            ld_uns_q;
    logic [1:0]      ld_off_q;
    logic [XLEN-1:0] rd_q;
    logic [XLEN-1:0] ext_data_c;

    logic issue_c;
    logic capture_c;
    logic req_clr_c;
    logic timeout_c;

    logic [25:0] unused_instr;
    assign unused_instr = Instr_M[25:0];

`ifdef LSU_TIMEOUT_EN
    logic [TO_CNT_W-1:0] to_cnt_q;
    logic                to_q;
`endif

    // Access decode and address checks
    always_comb begin
        dec_c      = lsu_decode(Instr_M[31:26]);
        misalign_c = ((dec_c.size == SZ_W) && (ALU_M[1:0] != 2'b00)) ||
                     ((dec_c.size == SZ_H) && ALU_M[0]);
        exc_addr_c = dec_c.valid && (misalign_c || (ALU_M > DM_TOP));
        exc_up_c   = (ExcCode_Min != EXC_NONE);
        go_c       = dec_c.valid && !exc_up_c && !exc_addr_c && !flush_M;
    end

    // Bus command for the current instruction: lane-replicated store data and byte enables
    always_comb begin
        cmd_c       = '0;
        cmd_c.we    = dec_c.store;
        cmd_c.addr  = {ALU_M[XLEN-1:2], 2'b00};
        cmd_c.be    = 4'b1111;
        cmd_c.wdata = '0;
        if (dec_c.store) begin
            case (dec_c.size)
                SZ_B: begin
                    cmd_c.be    = 4'b0001 << ALU_M[1:0];
                    cmd_c.wdata = {4{RT_M[7:0]}};
                end
                SZ_H: begin
                    cmd_c.be    = ALU_M[1] ? 4'b1100 : 4'b0011;
                    cmd_c.wdata = {2{RT_M[15:0]}};
                end
                default: begin
                    cmd_c.be    = 4'b1111;
                    cmd_c.wdata = RT_M;
                end
            endcase
        end
    end

    mem_stage_lsu_ext u_ext (
        .rdata  (bus.rdata),
        .size   (ld_size_q),
        .uns    (ld_uns_q),
        .off    (ld_off_q),
        .data_c (ext_data_c)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next state and transaction control; a killed access still waits for ack but skips DONE
    always_comb begin
        state_d   = state_q;
        issue_c   = 1'b0;
        capture_c = 1'b0;
        req_clr_c = 1'b0;
        timeout_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (go_c) begin
                    state_d = ST_REQ;
                    issue_c = 1'b1;
                end
            end
            ST_REQ: begin
                if (bus.ack) begin
                    req_clr_c = 1'b1;
                    if (kill_q || flush_M) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d   = ST_DONE;
                        capture_c = !cmd_q.we;
                    end
                end
`ifdef LSU_TIMEOUT_EN
                else if (to_cnt_q == TO_CNT_W'(TIMEOUT_CYC - 1)) begin
                    req_clr_c = 1'b1;
                    if (kill_q || flush_M) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d   = ST_DONE;
                        timeout_c = 1'b1;
                    end
                end
`endif
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Bus command, load context, kill flag and load result registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd_q     <= '0;
            req_q     <= 1'b0;
            kill_q    <= 1'b0;
            ld_size_q <= SZ_W;
            ld_uns_q  <= 1'b0;
            ld_off_q  <= 2'b00;
            rd_q      <= '0;
        end else begin
            if (issue_c) begin
                cmd_q     <= cmd_c;
                req_q     <= 1'b1;
                ld_size_q <= dec_c.size;
                ld_uns_q  <= dec_c.uns;
                ld_off_q  <= ALU_M[1:0];
            end else if (req_clr_c) begin
                req_q <= 1'b0;
            end

            if (req_clr_c)                          kill_q <= 1'b0;
            else if ((state_q == ST_REQ) && flush_M) kill_q <= 1'b1;

            if (capture_c)      rd_q <= ext_data_c;
            else if (timeout_c) rd_q <= '0;
        end
    end

`ifdef LSU_TIMEOUT_EN
    // REQ cycle counter and one-cycle timeout flag seen in DONE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt_q <= '0;
            to_q     <= 1'b0;
        end else begin
            to_cnt_q <= ((state_q == ST_REQ) && (state_d == ST_REQ)) ? to_cnt_q + TO_CNT_W'(1) : '0;
            to_q     <= timeout_c;
        end
    end
`endif

    // Pipeline-facing combinational outputs
    always_comb begin
        stall_M = ((state_q == ST_IDLE) && go_c) || (state_q == ST_REQ);
        if (exc_up_c)        ExcCode_Mout = ExcCode_Min;
        else if (exc_addr_c) ExcCode_Mout = dec_c.store ? EXC_ADES : EXC_ADEL;
        else                 ExcCode_Mout = EXC_NONE;
`ifdef LSU_TIMEOUT_EN
        if ((state_q == ST_DONE) && to_q) ExcCode_Mout = cmd_q.we ? EXC_ADES : EXC_ADEL;
`endif
    end

    assign bus.req   = req_q;
    assign bus.we    = cmd_q.we;
    assign bus.addr  = cmd_q.addr;
    assign bus.be    = cmd_q.be;
    assign bus.wdata = cmd_q.wdata;
    assign MemRd_M   = rd_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: loads, stores, address exceptions, flush and reset cases.
// With LSU_TIMEOUT_EN defined it also covers the bus timeout.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] Instr_M = '0;
    logic [31:0] RT_M = '0;
    logic [31:0] ALU_M = '0;
    logic [4:0]  ExcCode_Min = '0;
    logic        flush_M = 1'b0;
    logic [31:0] MemRd_M;
    logic        stall_M;
    logic [4:0]  ExcCode_Mout;

    int errors = 0;
    int checks = 0;

    mem_stage_lsu_if bus ();

    mem_stage_lsu dut (
        .clk          (clk),
        .reset        (reset),
        .Instr_M      (Instr_M),
        .RT_M         (RT_M),
        .ALU_M        (ALU_M),
        .ExcCode_Min  (ExcCode_Min),
        .flush_M      (flush_M),
        .bus          (bus),
        .MemRd_M      (MemRd_M),
        .stall_M      (stall_M),
        .ExcCode_Mout (ExcCode_Mout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ins(input logic [5:0] op);
        return {op, 26'd0};
    endfunction

    // Load with ack in the first REQ cycle
    task automatic run_load(input string tag, input logic [5:0] op, input logic [31:0] addr,
                            input logic [31:0] rdata, input logic [31:0] exp);
        tick();
        Instr_M = ins(op); ALU_M = addr; bus.ack = 1'b0;
        #2;
        chk({tag, " stall c1"}, 32'(stall_M), 32'd1);
        chk({tag, " req c1"}, 32'(bus.req), 32'd0);
        tick();
        bus.ack = 1'b1; bus.rdata = rdata;
        #2;
        chk({tag, " stall c2"}, 32'(stall_M), 32'd1);
        chk({tag, " req c2"}, 32'(bus.req), 32'd1);
        chk({tag, " addr"}, bus.addr, {addr[31:2], 2'b00});
        chk({tag, " be"}, 32'(bus.be), 32'hF);
        chk({tag, " we"}, 32'(bus.we), 32'd0);
        tick();
        bus.ack = 1'b0;
        #2;
        chk({tag, " stall c3"}, 32'(stall_M), 32'd0);
        chk({tag, " req c3"}, 32'(bus.req), 32'd0);
        chk({tag, " rd"}, MemRd_M, exp);
        tick();
        Instr_M = '0;
        #2;
        chk({tag, " stall after"}, 32'(stall_M), 32'd0);
    endtask

    // Store with ack in the first REQ cycle
    task automatic run_store(input string tag, input logic [5:0] op, input logic [31:0] addr,
                             input logic [31:0] rt, input logic [3:0] be, input logic [31:0] wd);
        tick();
        Instr_M = ins(op); ALU_M = addr; RT_M = rt; bus.ack = 1'b0;
        #2;
        chk({tag, " stall c1"}, 32'(stall_M), 32'd1);
        chk({tag, " exc"}, 32'(ExcCode_Mout), 32'd0);
        tick();
        bus.ack = 1'b1; bus.rdata = 32'h5555_5555;
        #2;
        chk({tag, " req"}, 32'(bus.req), 32'd1);
        chk({tag, " we"}, 32'(bus.we), 32'd1);
        chk({tag, " addr"}, bus.addr, {addr[31:2], 2'b00});
        chk({tag, " be"}, 32'(bus.be), 32'(be));
        chk({tag, " wdata"}, bus.wdata, wd);
        tick();
        bus.ack = 1'b0;
        #2;
        chk({tag, " stall c3"}, 32'(stall_M), 32'd0);
        chk({tag, " req c3"}, 32'(bus.req), 32'd0);
        tick();
        Instr_M = '0;
        #2;
    endtask

    // Access that must raise an exception without touching the bus
    task automatic run_exc(input string tag, input logic [5:0] op, input logic [31:0] addr,
                           input logic [4:0] exc_in, input logic [4:0] exp);
        tick();
        Instr_M = ins(op); ALU_M = addr; ExcCode_Min = exc_in;
        #2;
        chk({tag, " exc"}, 32'(ExcCode_Mout), 32'(exp));
        chk({tag, " stall"}, 32'(stall_M), 32'd0);
        tick();
        chk({tag, " req"}, 32'(bus.req), 32'd0);
        Instr_M = '0; ExcCode_Min = '0;
        #2;
        chk({tag, " exc clr"}, 32'(ExcCode_Mout), 32'd0);
    endtask

    initial begin
        bus.ack = 1'b0;
        bus.rdata = '0;

        #12;
        chk("rst req", 32'(bus.req), 32'd0);
        chk("rst we", 32'(bus.we), 32'd0);
        chk("rst be", 32'(bus.be), 32'd0);
        chk("rst addr", bus.addr, 32'd0);
        chk("rst wdata", bus.wdata, 32'd0);
        chk("rst rd", MemRd_M, 32'd0);
        chk("rst stall", 32'(stall_M), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run_load("lw", 6'h23, 32'h0000_0010, 32'h1234_5678, 32'h1234_5678);
        run_load("lb", 6'h20, 32'h0000_0013, 32'h80FF_FF7F, 32'hFFFF_FF80);
        run_load("lbu", 6'h24, 32'h0000_0013, 32'h80FF_FF7F, 32'h0000_0080);
        run_load("lh", 6'h21, 32'h0000_0002, 32'h9ABC_1234, 32'hFFFF_9ABC);
        run_load("lhu", 6'h25, 32'h0000_0002, 32'h9ABC_1234, 32'h0000_9ABC);
        run_load("lw top", 6'h23, 32'h0000_2FFC, 32'hCAFE_F00D, 32'hCAFE_F00D);

        // Flush during REQ: ack three cycles later, no DONE, MemRd_M keeps its old value
        tick();
        Instr_M = ins(6'h23); ALU_M = 32'h0000_0020;
        tick();
        flush_M = 1'b1;
        #2;
        chk("fl stall r1", 32'(stall_M), 32'd1);
        chk("fl req r1", 32'(bus.req), 32'd1);
        tick();
        flush_M = 1'b0;
        #2;
        chk("fl stall r2", 32'(stall_M), 32'd1);
        tick();
        bus.ack = 1'b1; bus.rdata = 32'hDEAD_BEEF;
        #2;
        chk("fl stall r3", 32'(stall_M), 32'd1);
        chk("fl req r3", 32'(bus.req), 32'd1);
        tick();
        bus.ack = 1'b0; Instr_M = '0;
        #2;
        chk("fl req after", 32'(bus.req), 32'd0);
        chk("fl stall after", 32'(stall_M), 32'd0);
        chk("fl rd kept", MemRd_M, 32'hCAFE_F00D);

        run_store("sh", 6'h29, 32'h0000_0002, 32'hAAAA_BEEF, 4'b1100, 32'hBEEF_BEEF);
        run_store("sh lo", 6'h29, 32'h0000_0004, 32'h1111_2222, 4'b0011, 32'h2222_2222);
        run_store("sb", 6'h28, 32'h0000_0001, 32'h0000_00A5, 4'b0010, 32'hA5A5_A5A5);
        run_store("sw", 6'h2B, 32'h0000_2FFC, 32'h0102_0304, 4'b1111, 32'h0102_0304);
        chk("rd after stores", MemRd_M, 32'hCAFE_F00D);

        run_exc("lw misal", 6'h23, 32'h0000_0006, 5'd0, 5'd4);
        run_exc("sw range", 6'h2B, 32'h0000_3000, 5'd0, 5'd5);
        run_exc("lh odd", 6'h21, 32'h0000_0001, 5'd0, 5'd4);
        run_exc("exc up", 6'h23, 32'h0000_0006, 5'd10, 5'd10);

        // Flush in IDLE: nothing issued
        tick();
        Instr_M = ins(6'h23); ALU_M = 32'h0000_0010; flush_M = 1'b1;
        #2;
        chk("fi stall", 32'(stall_M), 32'd0);
        tick();
        chk("fi req", 32'(bus.req), 32'd0);
        flush_M = 1'b0; Instr_M = '0;

        // Reset while REQ is pending drops req at once
        tick();
        Instr_M = ins(6'h23); ALU_M = 32'h0000_0030;
        tick();
        chk("rr req pre", 32'(bus.req), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("rr req", 32'(bus.req), 32'd0);
        Instr_M = '0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rr stall", 32'(stall_M), 32'd0);

`ifdef LSU_TIMEOUT_EN
        // No ack: req held 16 REQ cycles, then DONE with AdEL and zero data
        tick();
        Instr_M = ins(6'h23); ALU_M = 32'h0000_0040;
        tick();
        chk("to req r1", 32'(bus.req), 32'd1);
        repeat (15) tick();
        chk("to req r16", 32'(bus.req), 32'd1);
        chk("to stall r16", 32'(stall_M), 32'd1);
        tick();
        chk("to req done", 32'(bus.req), 32'd0);
        chk("to exc", 32'(ExcCode_Mout), 32'd4);
        chk("to rd", MemRd_M, 32'd0);
        chk("to stall", 32'(stall_M), 32'd0);
        tick();
        Instr_M = '0;
        #1;
        chk("to exc clr", 32'(ExcCode_Mout), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
